// File: rtl/simmem_banked_delay_calculator.sv
// Per-bank DRAM timing estimator: classifies each accepted request as row hit,
// closed or conflict and returns the delay until it completes.
module simmem_banked_delay_calculator #(
  parameter int unsigned NumBanks        = 4,
  parameter int unsigned IdWidth         = 4,
  parameter int unsigned RowWidth        = 8,
  parameter int unsigned DelayWidth      = 8,
  parameter int unsigned RowHitCost      = 2,
  parameter int unsigned RowClosedCost   = 6,
  parameter int unsigned RowConflictCost = 10,
  parameter int unsigned WriteExtraCost  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [IdWidth-1:0]          local_id_i,
  input  logic [$clog2(NumBanks)-1:0] bank_i,
  input  logic [RowWidth-1:0]         row_i,
  input  logic                        is_write_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [IdWidth-1:0]          local_id_o,
  output logic [DelayWidth-1:0]       delay_o
);

  localparam int unsigned BankW = $clog2(NumBanks);
  localparam int unsigned SumW  = DelayWidth + 2;

  typedef enum logic [1:0] {
    CLS_HIT,
    CLS_CLOSED,
    CLS_CONFLICT
  } access_cls_e;

  logic [NumBanks-1:0]   row_valid;
  logic [RowWidth-1:0]   open_row [NumBanks];
  logic [DelayWidth-1:0] busy     [NumBanks];

  access_cls_e           cls;
  logic [SumW-1:0]       cost;
  logic [SumW-1:0]       delay_sum;
  logic [DelayWidth-1:0] delay_sat;
  logic                  accept;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    cls = CLS_CONFLICT;
    if (!row_valid[bank_i]) begin
      cls = CLS_CLOSED;
    end else if (open_row[bank_i] == row_i) begin
      cls = CLS_HIT;
    end
  end

  always_comb begin
    cost = SumW'(RowConflictCost);
    case (cls)
      CLS_HIT:    cost = SumW'(RowHitCost);
      CLS_CLOSED: cost = SumW'(RowClosedCost);
      default:    cost = SumW'(RowConflictCost);
    endcase
    if (is_write_i) begin
      cost = cost + SumW'(WriteExtraCost);
    end
  end

  // The two guard bits catch any overflow past the delay field; clamp to all-ones.
  assign delay_sum = {2'b00, busy[bank_i]} + cost;
  assign delay_sat = (delay_sum[SumW-1 -: 2] != 2'b00) ? '1 : delay_sum[DelayWidth-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_valid <= '0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
        open_row[b] <= '0;
        busy[b]     <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        if (accept && (bank_i == BankW'(b))) begin
          busy[b]      <= delay_sat;
          open_row[b]  <= row_i;
          row_valid[b] <= 1'b1;
        end else if (busy[b] != '0) begin
          busy[b] <= busy[b] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      local_id_o  <= '0;
      delay_o     <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      local_id_o  <= local_id_i;
      delay_o     <= delay_sat;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simmem_banked_delay_calculator.sv
// Bench for simmem_banked_delay_calculator: directed vector table, hand-written
// backpressure / saturation / reset sequences, and randomized traffic vs a model.
module tb_simmem_banked_delay_calculator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready_o;
  logic [3:0] local_id = '0;
  logic [1:0] bank = '0;
  logic [7:0] row = '0;
  logic       is_write = 1'b0;
  logic       out_valid_o;
  logic       out_ready = 1'b1;
  logic [3:0] local_id_o;
  logic [7:0] delay_o;

  logic       b_valid = 1'b0;
  logic       b_in_ready;
  logic [3:0] b_id = '0;
  logic [1:0] b_bank = '0;
  logic [7:0] b_row = '0;
  logic       b_out_valid;
  logic [3:0] b_local_id;
  logic [3:0] b_delay;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simmem_banked_delay_calculator dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .local_id_i(local_id), .bank_i(bank), .row_i(row), .is_write_i(is_write),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .local_id_o(local_id_o), .delay_o(delay_o)
  );

  simmem_banked_delay_calculator #(.DelayWidth(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_valid), .in_ready_o(b_in_ready),
    .local_id_i(b_id), .bank_i(b_bank), .row_i(b_row), .is_write_i(1'b0),
    .out_valid_o(b_out_valid), .out_ready_i(1'b1),
    .local_id_o(b_local_id), .delay_o(b_delay)
  );

  // Reference model: each bank remembers the absolute cycle at which it becomes free.
  int   m_cyc = 0;
  int   m_free_at [4];
  bit   m_open    [4];
  int   m_row     [4];
  bit   m_valid;
  int   m_id;
  int   m_delay;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_free_at[b] = 0;
      m_open[b]    = 0;
      m_row[b]     = 0;
    end
    m_valid = 0;
    m_id    = 0;
    m_delay = 0;
  endtask

  function automatic int model_delay(input int b, input int r, input bit wr, input int maxd);
    int busy_now, cost, d;
    busy_now = m_free_at[b] - m_cyc;
    if (busy_now < 0) busy_now = 0;
    if (!m_open[b])         cost = 6;
    else if (m_row[b] == r) cost = 2;
    else                    cost = 10;
    if (wr) cost += 1;
    d = busy_now + cost;
    return (d > maxd) ? maxd : d;
  endfunction

  // Called just after a negedge: drive, predict, clock once, check at the next negedge.
  task automatic step(input logic v, input logic [3:0] id, input logic [1:0] bk,
                      input logic [7:0] rw, input logic wr, input logic ordy);
    bit rdy;
    int d;
    in_valid  = v;
    local_id  = id;
    bank      = bk;
    row       = rw;
    is_write  = wr;
    out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", int'(in_ready_o), int'(rdy));
    if (v && rdy) begin
      d = model_delay(int'(bk), int'(rw), wr, 255);
      m_free_at[bk] = m_cyc + 1 + d;
      m_open[bk]    = 1;
      m_row[bk]     = int'(rw);
      m_valid       = 1;
      m_id          = int'(id);
      m_delay       = d;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    m_cyc++;
    @(negedge clk);
    check("out_valid", int'(out_valid_o), int'(m_valid));
    if (m_valid) begin
      check("local_id", int'(local_id_o), m_id);
      check("delay", int'(delay_o), m_delay);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    b_valid  = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_local_id", int'(local_id_o), 0);
    check("rst_delay", int'(delay_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("post_rst_in_ready", int'(in_ready_o), 1);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] id;
    logic [1:0] bank;
    logic [7:0] row;
    logic       wr;
    logic       ordy;
    logic       ev;
    int         ed;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] id, input logic [1:0] bk,
                              input logic [7:0] rw, input logic wr, input logic ev, input int ed);
    vec_t t;
    t.v = v; t.id = id; t.bank = bk; t.row = rw; t.wr = wr;
    t.ordy = 1'b1; t.ev = ev; t.ed = ed;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int sat_exp[5];

    tbl.push_back(mk(1'b1, 4'd1, 2'd0, 8'd5, 1'b0, 1'b1, 6));   // closed
    tbl.push_back(mk(1'b1, 4'd2, 2'd0, 8'd5, 1'b0, 1'b1, 8));   // hit on busy bank
    tbl.push_back(mk(1'b1, 4'd3, 2'd1, 8'd3, 1'b1, 1'b1, 7));   // closed write
    tbl.push_back(mk(1'b1, 4'd4, 2'd2, 8'd0, 1'b0, 1'b1, 6));   // other bank independent
    for (int i = 0; i < 20; i++) tbl.push_back(mk(1'b0, 4'd0, 2'd0, 8'd0, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1'b1, 4'd5, 2'd1, 8'd4, 1'b0, 1'b1, 10));  // conflict, bank idle

    model_reset();
    #2;
    check("init_out_valid", int'(out_valid_o), 0);
    check("init_delay", int'(delay_o), 0);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].id, tbl[i].bank, tbl[i].row, tbl[i].wr, tbl[i].ordy);
      check("tbl_valid", int'(out_valid_o), int'(tbl[i].ev));
      if (tbl[i].ev) check("tbl_delay", int'(delay_o), tbl[i].ed);
    end

    // Backpressure: pending result held, requests refused, bank state untouched.
    do_reset();
    step(1'b1, 4'd1, 2'd0, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd7, 2'd0, 8'd9, 1'b0, 1'b0);
      check("bp_hold_id", int'(local_id_o), 1);
      check("bp_hold_delay", int'(delay_o), 6);
    end
    step(1'b1, 4'd7, 2'd0, 8'd9, 1'b0, 1'b1);
    check("bp_release_id", int'(local_id_o), 7);
    check("bp_release_delay", int'(delay_o), 11);
    step(1'b0, 4'd0, 2'd0, 8'd0, 1'b0, 1'b1);

    // Saturation on the 4-bit delay instance.
    do_reset();
    sat_exp = '{6, 15, 15, 15, 15};
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1;
      b_id    = 4'(i);
      b_bank  = 2'd3;
      b_row   = 8'(i % 2);
      @(posedge clk);
      @(negedge clk);
      check("sat_valid", int'(b_out_valid), 1);
      check("sat_delay", int'(b_delay), sat_exp[i]);
    end
    b_valid = 1'b0;

    // Reset while a result is pending and the bank is busy.
    do_reset();
    step(1'b1, 4'd2, 2'd0, 8'd5, 1'b0, 1'b0);
    check("pre_rst_valid", int'(out_valid_o), 1);
    do_reset();
    step(1'b1, 4'd3, 2'd0, 8'd5, 1'b0, 1'b1);
    check("post_rst_delay", int'(delay_o), 6);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
           8'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/simmem_banked_delay_calculator.md
SIMMEM_BANKED_DELAY_CALCULATOR -- requirements
Module: simmem_banked_delay_calculator

Interface
REQ-001 SHALL have parameter NumBanks, default 4, number of simulated DRAM banks (power of two, >=2).
REQ-002 SHALL have parameter IdWidth, default 4, local identifier width.
REQ-003 SHALL have parameter RowWidth, default 8, row address width.
REQ-004 SHALL have parameter DelayWidth, default 8, delay field width.
REQ-005 SHALL have parameters RowHitCost=2, RowClosedCost=6, RowConflictCost=10, WriteExtraCost=1, all cycle counts.
REQ-006 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid_i  input  1  request valid.
REQ-009 SHALL have port in_ready_o  output  1  request accepted when high with in_valid_i.
REQ-010 SHALL have port local_id_i  input  IdWidth  request identifier.
REQ-011 SHALL have port bank_i  input  $clog2(NumBanks)  target bank.
REQ-012 SHALL have port row_i  input  RowWidth  target row.
REQ-013 SHALL have port is_write_i  input  1  high for write, low for read.
REQ-014 SHALL have port out_valid_o  output  1  result valid.
REQ-015 SHALL have port out_ready_i  input  1  consumer ready.
REQ-016 SHALL have port local_id_o  output  IdWidth  identifier of the result.
REQ-017 SHALL have port delay_o  output  DelayWidth  computed delay, in cycles, from acceptance.

Function
REQ-018 SHALL hold per bank: row_valid (1 bit), open_row (RowWidth), busy (DelayWidth).
REQ-019 SHALL classify an accepted request as: hit if row_valid and open_row==row_i; closed if !row_valid; conflict otherwise.
REQ-020 SHALL compute cost = RowHitCost / RowClosedCost / RowConflictCost per class, plus WriteExtraCost if is_write_i.
REQ-021 SHALL compute delay = busy[bank_i] + cost, in DelayWidth+2 bits, saturated to 2^DelayWidth-1.
REQ-022 SHALL, on acceptance (in_valid_i && in_ready_o), load busy[bank_i] with the saturated delay, set open_row[bank_i]=row_i and row_valid[bank_i]=1.
REQ-023 SHALL decrement every non-accessed bank's busy by 1 per cycle, holding at 0; the accessed bank is loaded, not decremented, that cycle.
REQ-024 SHALL register local_id_i and the delay into a one-entry output stage on acceptance; latency exactly 1 cycle.
REQ-025 SHALL drive in_ready_o = !out_valid_o || out_ready_i (combinational, no dependence on in_valid_i).
REQ-026 SHALL sustain one request per cycle when out_ready_i is held high.
REQ-027 SHALL, on simultaneous output handshake and input acceptance, replace the output entry with the new result, out_valid_o staying 1.
REQ-028 SHALL clear out_valid_o on output handshake with no acceptance.
REQ-029 SHALL hold local_id_o and delay_o stable while out_valid_o && !out_ready_i.
REQ-030 SHALL continue busy decrement during backpressure.
REQ-031 SHALL not modify any bank state when in_valid_i is low or in_ready_o is low.

Reset
REQ-032 SHALL, while rst_i is high, drive out_valid_o=0, local_id_o=0, delay_o=0, and clear all busy, row_valid and open_row to 0, asynchronously.
REQ-033 SHALL discard any pending output entry and bank state on reset mid-operation; first request after reset is classified closed.
REQ-034 SHALL drive in_ready_o=1 immediately after reset deassertion.

Verification
REQ-035 SHALL cover: after reset, read bank 0 row 5 -> next cycle out_valid_o=1, delay_o=6.
REQ-036 SHALL cover: read bank 0 row 5 in cycle t, read bank 0 row 5 in t+1 (out_ready_i=1) -> delays 6 then 8.
REQ-037 SHALL cover: write bank 1 row 3, 20 idle cycles, read bank 1 row 4 -> delays 7 then 10; read bank 2 in between unaffected by bank 1 busy (delay 6).
REQ-038 SHALL cover: out_ready_i=0 with out_valid_o=1 for 5 cycles -> in_ready_o=0, outputs stable, no bank update; then out_ready_i=1 -> pending result consumed, next request accepted same cycle.
REQ-039 SHALL cover: DelayWidth=4 instance, back-to-back conflicts on bank 3 alternating rows 0/1 -> delay_o 6, 15, 15, ... (saturated).
REQ-040 SHALL cover: rst_i asserted while out_valid_o=1 and busy nonzero -> out_valid_o=0 asynchronously; post-reset read bank 0 row 5 -> delay_o=6.
